// File: rtl/billiard_pkg.sv
// Shared types for the billiard pocketing logic: hole ids, ball indices,
// the pocket event record and the scheduler state encoding.
package billiard_pkg;

  localparam int NUM_HOLES = 6;
  localparam int MAX_BALLS = 16;

  typedef logic [2:0]                   hole_id_t;
  typedef logic [$clog2(MAX_BALLS)-1:0] ball_idx_t;

  typedef struct packed {
    ball_idx_t ball;
    hole_id_t  hole;
  } pocket_event_t;

  typedef enum logic {
    COLLECT = 1'b0,
    SCAN    = 1'b1
  } sched_state_t;

  // Holes are numbered 1..NUM_HOLES; 0 and 7 are not real holes.
  function automatic logic hole_valid(input hole_id_t h);
    return (h != 3'd0) && (h <= 3'(NUM_HOLES));
  endfunction

endpackage

// File: rtl/pocket_event_fifo.sv
// Small FIFO of pocket events. Head is presented combinationally and forced
// to zero while empty so the event outputs read 0 with no event pending.
module pocket_event_fifo
  import billiard_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  pocket_event_t push_data,
  input  logic          pop,
  output pocket_event_t head,
  output logic          full,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);

  pocket_event_t mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW:0]   count_reg;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_reg == (PW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  // A push into a full queue is accepted only when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr_reg];

  // Storage write; contents need no reset because the pointers qualify them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (PW+1)'(1);
        2'b01:   count_reg <= count_reg - (PW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/pocket_scheduler.sv
// Captures ball/hit-zone pixel coincidences during a frame, then scans the
// collected hits once per frame and queues one event per newly pocketed ball.
module pocket_scheduler
  import billiard_pkg::*;
#(
  parameter int NUM_BALLS  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         startOfFrame,
  input  logic                         newGame,
  input  logic                         Hit_Hole_DR,
  input  logic [2:0]                   Hole_ID,
  input  logic [NUM_BALLS-1:0]         ball_DR,
  input  logic                         event_ready,
  output logic                         event_valid,
  output logic [$clog2(NUM_BALLS)-1:0] event_ball,
  output logic [2:0]                   event_hole,
  output logic                         event_scratch,
  output logic [NUM_BALLS-1:0]         pocketed,
  output logic                         busy,
  output logic                         frame_overrun
);

  localparam int IDX_W = $clog2(NUM_BALLS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BALLS - 1);

  sched_state_t                 state_reg, state_next;
  logic [IDX_W-1:0]             idx_reg;
  logic [NUM_BALLS-1:0]         ball_dr_d_reg;
  logic [NUM_BALLS-1:0]         cap_hit_reg, cap_hit_next;
  hole_id_t [NUM_BALLS-1:0]     cap_hole_reg, cap_hole_next;
  logic [NUM_BALLS-1:0]         scan_hit_reg;
  hole_id_t [NUM_BALLS-1:0]     scan_hole_reg;
  logic [NUM_BALLS-1:0]         pocketed_reg, pocket_set;
  logic [NUM_BALLS-1:0]         coinc;
  logic                         overrun_reg;
  logic                         transfer, advance, push, examine_hit;
  logic                         fifo_full, fifo_empty, fifo_pop;
  pocket_event_t                fifo_head, push_data;
  logic                         hole_ok;

  assign hole_ok = Hit_Hole_DR && hole_valid(Hole_ID);

  // Per-ball capture: first valid hole in raster order wins within a frame.
  for (genvar gi = 0; gi < NUM_BALLS; gi++) begin : g_ball
    assign coinc[gi]         = ball_dr_d_reg[gi] && hole_ok && !pocketed_reg[gi];
    assign cap_hit_next[gi]  = transfer ? coinc[gi] : (cap_hit_reg[gi] || coinc[gi]);
    assign cap_hole_next[gi] = transfer ? (coinc[gi] ? Hole_ID : 3'd0)
                             : (coinc[gi] && !cap_hit_reg[gi]) ? Hole_ID : cap_hole_reg[gi];
    assign pocket_set[gi]    = push && (idx_reg == IDX_W'(gi));
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset || newGame) state_reg <= COLLECT;
    else                  state_reg <= state_next;
  end

  // FSM next-state: one frame-start kicks a scan, the last index ends it.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      COLLECT: if (startOfFrame) state_next = SCAN;
      SCAN:    if (advance && idx_reg == LAST_IDX) state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  // FSM outputs: push a pending hit unless the queue is full (stall on that index).
  always_comb begin
    busy        = (state_reg == SCAN);
    examine_hit = scan_hit_reg[idx_reg] && !pocketed_reg[idx_reg];
    transfer    = !busy && startOfFrame;
    push        = busy && examine_hit && !fifo_full;
    advance     = busy && !(examine_hit && fifo_full);
  end

  // Align ball requests with the one-cycle-later hit-zone request.
  always_ff @(posedge clk) begin
    if (reset) ball_dr_d_reg <= '0;
    else       ball_dr_d_reg <= ball_DR;
  end

  // Capture/scan buffers, pocketed mask, scan index and overrun flag.
  always_ff @(posedge clk) begin
    if (reset || newGame) begin
      cap_hit_reg   <= '0;
      cap_hole_reg  <= '0;
      scan_hit_reg  <= '0;
      scan_hole_reg <= '0;
      pocketed_reg  <= '0;
      idx_reg       <= '0;
      overrun_reg   <= 1'b0;
    end else begin
      cap_hit_reg  <= cap_hit_next;
      cap_hole_reg <= cap_hole_next;
      pocketed_reg <= pocketed_reg | pocket_set;
      if (transfer) begin
        scan_hit_reg  <= cap_hit_reg;
        scan_hole_reg <= cap_hole_reg;
        idx_reg       <= '0;
      end else if (advance && idx_reg != LAST_IDX) begin
        idx_reg <= idx_reg + IDX_W'(1);
      end
      if (startOfFrame && busy) overrun_reg <= 1'b1;
    end
  end

  assign push_data.ball = ball_idx_t'(idx_reg);
  assign push_data.hole = scan_hole_reg[idx_reg];
  assign fifo_pop       = !fifo_empty && event_ready;

  pocket_event_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .clear    (newGame),
    .push     (push),
    .push_data(push_data),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign event_valid   = !fifo_empty;
  assign event_ball    = fifo_head.ball[IDX_W-1:0];
  assign event_hole    = fifo_head.hole;
  assign event_scratch = !fifo_empty && (fifo_head.ball == '0);
  assign pocketed      = pocketed_reg;
  assign frame_overrun = overrun_reg;

endmodule

// File: tb/tb_pocket_scheduler.sv
// Random and directed stimulus for pocket_scheduler, checked every cycle
// against a frame/queue-level reference model.
module tb_pocket_scheduler;

  localparam int NB    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          startOfFrame = 1'b0;
  logic          newGame = 1'b0;
  logic          Hit_Hole_DR = 1'b0;
  logic [2:0]    Hole_ID = 3'd0;
  logic [NB-1:0] ball_DR = '0;
  logic          event_ready = 1'b1;
  logic          event_valid;
  logic [3:0]    event_ball;
  logic [2:0]    event_hole;
  logic          event_scratch;
  logic [NB-1:0] pocketed;
  logic          busy;
  logic          frame_overrun;

  pocket_scheduler #(.NUM_BALLS(NB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .newGame(newGame),
    .Hit_Hole_DR(Hit_Hole_DR), .Hole_ID(Hole_ID), .ball_DR(ball_DR),
    .event_ready(event_ready), .event_valid(event_valid), .event_ball(event_ball),
    .event_hole(event_hole), .event_scratch(event_scratch), .pocketed(pocketed),
    .busy(busy), .frame_overrun(frame_overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: hits per frame, scan walked ball by ball, events in a queue.
  bit m_poc[NB], m_new_poc[NB], m_cap_hit[NB], m_scan_hit[NB], m_prev_dr[NB], m_coinc[NB];
  int m_cap_hole[NB], m_scan_hole[NB];
  bit m_scanning, m_overrun, m_live;
  int m_pos, m_qsize;
  int q_ball[$], q_hole[$];

  task automatic model_clear();
    for (int i = 0; i < NB; i++) begin
      m_poc[i] = 0; m_cap_hit[i] = 0; m_scan_hit[i] = 0;
      m_cap_hole[i] = 0; m_scan_hole[i] = 0;
    end
    m_scanning = 0; m_overrun = 0; m_pos = 0;
    q_ball.delete(); q_hole.delete();
  endtask

  always @(posedge clk) begin
    if (reset) begin
      model_clear();
      for (int i = 0; i < NB; i++) m_prev_dr[i] = 0;
    end else begin
      if (newGame) begin
        model_clear();
      end else begin
        bit was_scanning;
        was_scanning = m_scanning;
        m_qsize = q_ball.size();
        for (int i = 0; i < NB; i++) begin
          m_coinc[i]   = m_prev_dr[i] && Hit_Hole_DR && (int'(Hole_ID) inside {[1:6]}) && !m_poc[i];
          m_new_poc[i] = m_poc[i];
        end
        if (m_qsize > 0 && event_ready) begin
          void'(q_ball.pop_front());
          void'(q_hole.pop_front());
        end
        if (was_scanning) begin
          if (m_scan_hit[m_pos] && !m_poc[m_pos]) begin
            if (m_qsize < DEPTH) begin
              q_ball.push_back(m_pos);
              q_hole.push_back(m_scan_hole[m_pos]);
              m_new_poc[m_pos] = 1;
              m_pos++;
            end
          end else begin
            m_pos++;
          end
          if (m_pos == NB) m_scanning = 0;
        end
        if (startOfFrame) begin
          if (!was_scanning) begin
            for (int i = 0; i < NB; i++) begin
              m_scan_hit[i]  = m_cap_hit[i];
              m_scan_hole[i] = m_cap_hole[i];
              m_cap_hit[i]   = 0;
              m_cap_hole[i]  = 0;
            end
            m_pos = 0;
            m_scanning = 1;
          end else begin
            m_overrun = 1;
          end
        end
        for (int i = 0; i < NB; i++) begin
          if (m_coinc[i] && !m_cap_hit[i]) begin
            m_cap_hit[i]  = 1;
            m_cap_hole[i] = int'(Hole_ID);
          end
          m_poc[i] = m_new_poc[i];
        end
      end
      for (int i = 0; i < NB; i++) m_prev_dr[i] = ball_DR[i];
    end
    m_live = 1;
  end

  // Compare every DUT output against the model mid-cycle.
  always @(negedge clk) begin
    if (m_live) begin
      logic [NB-1:0] exp_poc;
      for (int i = 0; i < NB; i++) exp_poc[i] = m_poc[i];
      check("event_valid", 32'(event_valid), 32'(q_ball.size() > 0));
      if (q_ball.size() > 0) begin
        check("event_ball", 32'(event_ball), 32'(q_ball[0]));
        check("event_hole", 32'(event_hole), 32'(q_hole[0]));
        check("event_scratch", 32'(event_scratch), 32'(q_ball[0] == 0));
      end else begin
        check("idle_head", {25'd0, event_scratch, event_hole, event_ball}, 32'd0);
      end
      check("pocketed", 32'(pocketed), 32'(exp_poc));
      check("busy", 32'(busy), 32'(m_scanning));
      check("frame_overrun", 32'(frame_overrun), 32'(m_overrun));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hit(input int ball, input int hole);
    ball_DR = '0; ball_DR[ball] = 1'b1;
    tick();
    ball_DR = '0; Hit_Hole_DR = 1'b1; Hole_ID = 3'(hole);
    tick();
    Hit_Hole_DR = 1'b0; Hole_ID = 3'd0;
  endtask

  task automatic sof();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  initial begin
    int frame_len, frame_cnt, frames;
    tick(3);
    reset = 1'b0;
    tick(2);

    // Ball 3 into hole 2, then the same ball again in later frames.
    hit(3, 2); tick(2); sof(); tick(25);
    hit(3, 5); sof(); tick(20);
    // First hole in raster order wins.
    hit(5, 4); hit(5, 1); sof(); tick(20);
    // Hole 7 and a misaligned request must not capture.
    hit(6, 7);
    ball_DR[8] = 1'b1; Hit_Hole_DR = 1'b1; Hole_ID = 3'd3; tick();
    ball_DR = '0; Hit_Hole_DR = 1'b0; Hole_ID = 3'd0; tick();
    sof(); tick(20);

    // Queue fills, scan stalls at ball 12, overrun, then drain.
    newGame = 1'b1; tick(); newGame = 1'b0;
    event_ready = 1'b0;
    hit(0, 1); hit(2, 3); hit(7, 6); hit(9, 2); hit(12, 5);
    sof(); tick(20);
    sof(); hit(4, 4); tick(5);
    event_ready = 1'b1; tick(20);
    sof(); tick(22);

    // newGame, then reset, in the middle of a scan with events queued.
    event_ready = 1'b0;
    hit(1, 1); hit(5, 2); hit(10, 3); sof(); tick(7);
    newGame = 1'b1; tick(); newGame = 1'b0; tick(3);
    hit(2, 6); hit(6, 4); hit(11, 3); sof(); tick(8);
    reset = 1'b1; tick(); reset = 1'b0; tick(3);
    event_ready = 1'b1;

    // Random frames with random readiness, occasional newGame/reset.
    frame_len = 30; frame_cnt = 0; frames = 0;
    for (int c = 0; c < 6000; c++) begin
      reset        = ($urandom_range(2999) == 0);
      newGame      = ($urandom_range(499) == 0);
      ball_DR      = '0;
      if ($urandom_range(2) == 0) ball_DR[$urandom_range(NB-1)] = 1'b1;
      if ($urandom_range(9) == 0) ball_DR[$urandom_range(NB-1)] = 1'b1;
      Hit_Hole_DR  = ($urandom_range(2) == 0);
      Hole_ID      = 3'($urandom_range(7));
      event_ready  = ($urandom_range(3) != 0) || (frames % 5 == 4 && $urandom_range(1) == 0);
      if ((frames % 7) == 3) event_ready = ($urandom_range(5) == 0);
      startOfFrame = 1'b0;
      if (++frame_cnt >= frame_len) begin
        startOfFrame = 1'b1;
        frame_cnt = 0;
        frame_len = $urandom_range(8, 60);
        frames++;
        if (frames % 12 == 0) newGame = 1'b1;
      end
      tick();
    end
    reset = 1'b0; newGame = 1'b0; startOfFrame = 1'b0;
    ball_DR = '0; Hit_Hole_DR = 1'b0; event_ready = 1'b1;
    tick(30);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
